// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-port arbitrated word memory.
package mem_arb_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

  // Any address bit above the word index makes the access out of range.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned aw);
    return (addr >> (aw + 2)) == 32'h0;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// One-of-N request arbiter: round-robin when MEM_ARB_RR_EN is defined,
// fixed lowest-index priority otherwise.
module mem_rr_arbiter #(
  parameter int unsigned NPORTS = 2,
  localparam int unsigned IW    = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req,
  input  logic              adv,
  output logic [NPORTS-1:0] gnt,
  output logic [IW-1:0]     gnt_idx
);

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] prio;

  always_comb begin
    int unsigned   pos;
    logic [IW-1:0] idx;
    logic          found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    idx     = '0;
    // Scan ports starting at prio, wrapping modulo NPORTS.
    for (int unsigned i = 0; i < NPORTS; i++) begin
      pos = 32'(prio) + i;
      if (pos >= NPORTS) pos = pos - NPORTS;
      idx = IW'(pos);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= '0;
    end else if (adv && (|req)) begin
      prio <= (gnt_idx == IW'(NPORTS - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end
`else
  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      idx = IW'(i);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst, adv};
`endif

endmodule

// File: rtl/mem_arb_nport.sv
// N-port arbitrated single-array word memory with post-reset clear FSM,
// byte strobes and sticky range error. Optional macro: MEM_ARB_RR_EN.
module mem_arb_nport
  import mem_arb_pkg::*;
#(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned DEPTH  = 128,
  localparam int unsigned IW    = (NPORTS > 1) ? $clog2(NPORTS) : 1,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORTS-1:0]       mem_val,
  output logic [NPORTS-1:0]       mem_wait,
  input  logic [NPORTS-1:0]       mem_type,
  input  logic [NPORTS-1:0][31:0] mem_addr,
  input  logic [NPORTS-1:0][31:0] mem_wdata,
  input  logic [NPORTS-1:0][3:0]  mem_strb,
  output logic [NPORTS-1:0][31:0] mem_rdata,
  output logic                    init_done,
  output logic                    err,
  output logic [IW-1:0]           err_port
);

  logic [31:0] mem [DEPTH];

  state_e        state, next_state;
  logic [AW-1:0] clr_idx, clr_next;

  logic [NPORTS-1:0] gnt;
  logic [IW-1:0]     gnt_idx;
  logic              ready;
  logic              accept;
  logic [31:0]       g_addr;
  logic              g_write;
  logic              g_ok;
  logic [AW-1:0]     g_word;
  logic [31:0]       rd_word;

  assign ready  = (state == READY);
  assign accept = ready && (|mem_val);

  mem_rr_arbiter #(
    .NPORTS(NPORTS)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (mem_val),
    .adv    (ready),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign g_addr  = mem_addr[gnt_idx];
  assign g_write = (mem_type[gnt_idx] == MEM_WRITE);
  assign g_ok    = addr_in_range(g_addr, AW);
  assign g_word  = g_addr[AW+1:2];
  assign rd_word = mem[g_word];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_idx <= '0;
    end else begin
      state   <= next_state;
      clr_idx <= clr_next;
    end
  end

  always_comb begin
    next_state = state;
    clr_next   = clr_idx;
    init_done  = 1'b0;
    unique case (state)
      INIT: begin
        clr_next = clr_idx + AW'(1);
        if (clr_idx == AW'(DEPTH - 1)) next_state = READY;
      end
      READY: begin
        init_done = 1'b1;
      end
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[clr_idx] <= 32'h0;
      end else if (accept && g_write && g_ok) begin
        mem[g_word] <= strb_merge(mem[g_word], mem_wdata[gnt_idx], mem_strb[gnt_idx]);
      end
    end
  end

  always_comb begin
    mem_wait  = '1;
    mem_rdata = '0;
    if (ready) begin
      mem_wait = mem_val & ~gnt;
      if (accept && !g_write && g_ok) mem_rdata[gnt_idx] = rd_word;
    end
  end

  // Only the first out-of-range accept is recorded until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      err_port <= '0;
    end else if (accept && !g_ok && !err) begin
      err      <= 1'b1;
      err_port <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_mem_arb_nport.sv
// Directed self-checking bench for mem_arb_nport (NPORTS=3, DEPTH=128).
module tb_mem_arb_nport;

  localparam int unsigned NP = 3;
  localparam int unsigned DP = 128;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NP-1:0]     mem_val;
  logic [NP-1:0]     mem_wait;
  logic [NP-1:0]     mem_type;
  logic [NP-1:0][31:0] mem_addr;
  logic [NP-1:0][31:0] mem_wdata;
  logic [NP-1:0][3:0]  mem_strb;
  logic [NP-1:0][31:0] mem_rdata;
  logic              init_done;
  logic              err;
  logic [1:0]        err_port;

  int checks   = 0;
  int failures = 0;

  mem_arb_nport #(
    .NPORTS(NP),
    .DEPTH (DP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_val  (mem_val),
    .mem_wait (mem_wait),
    .mem_type (mem_type),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_strb (mem_strb),
    .mem_rdata(mem_rdata),
    .init_done(init_done),
    .err      (err),
    .err_port (err_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    mem_val   = '0;
    mem_type  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_strb  = '0;
  endtask

  task automatic req(input int p, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    mem_val[p]   = 1'b1;
    mem_type[p]  = wr;
    mem_addr[p]  = a;
    mem_wdata[p] = d;
    mem_strb[p]  = s;
  endtask

  task automatic clear_sequence(input string tag);
    for (int c = 0; c < 128; c++) begin
      check($sformatf("%s_wait_c%0d", tag, c), 32'(mem_wait), 32'h7);
      check($sformatf("%s_done_c%0d", tag, c), 32'(init_done), 32'h0);
      tick();
    end
    check({tag, "_done_rise"}, 32'(init_done), 32'h1);
    check({tag, "_wait_idle"}, 32'(mem_wait), 32'h0);
  endtask

  initial begin
    int g;
    logic [2:0] one;
    rst = 1'b1;
    idle();
    @(negedge clk);
    tick();
    tick();
    #1;
    check("rst_wait", 32'(mem_wait), 32'h7);
    check("rst_rdata0", mem_rdata[0], 32'h0);
    check("rst_rdata2", mem_rdata[2], 32'h0);
    check("rst_done", 32'(init_done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_errport", 32'(err_port), 32'h0);

    // Requests during INIT must be ignored.
    rst = 1'b0;
    req(0, 1'b0, 32'h40, 32'h0, 4'h0);
    #1;
    check("init_ignore_rdata", mem_rdata[0], 32'h0);
    idle();
    clear_sequence("clr1");

    req(0, 1'b0, 32'h40, 32'h0, 4'h0);
    #1;
    check("rd40_wait", 32'(mem_wait), 32'h0);
    check("rd40_data", mem_rdata[0], 32'h0);
    tick(); idle();

    req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b0101);
    #1;
    check("wr10_wait", 32'(mem_wait), 32'h0);
    check("wr10_rdata", mem_rdata[0], 32'h0);
    tick(); idle();
    req(1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    check("rd10_strb", mem_rdata[1], 32'h00AD00EF);
    check("rd10_other", mem_rdata[0], 32'h0);
    tick(); idle();

    req(2, 1'b1, 32'h20, 32'h12345678, 4'b1111);
    tick(); idle();
    req(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    tick(); idle();
    req(0, 1'b0, 32'h20, 32'h0, 4'h0);
    #1;
    check("rd20_noop_strb", mem_rdata[0], 32'h12345678);
    tick(); idle();

    req(0, 1'b1, 32'h1FC, 32'hCAFEF00D, 4'b1111);
    tick(); idle();
    req(1, 1'b0, 32'h1FC, 32'h0, 4'h0);
    #1;
    check("rd1fc_top_word", mem_rdata[1], 32'hCAFEF00D);
    check("rd1fc_no_err", 32'(err), 32'h0);
    tick(); idle();

    // A lone port-2 grant leaves the round-robin pointer at 0.
    req(2, 1'b0, 32'h20, 32'h0, 4'h0);
    #1;
    check("rd20_p2", mem_rdata[2], 32'h12345678);
    tick(); idle();

    for (int c = 0; c < 6; c++) begin
      req(0, 1'b0, 32'h10, 32'h0, 4'h0);
      req(1, 1'b0, 32'h10, 32'h0, 4'h0);
      req(2, 1'b0, 32'h10, 32'h0, 4'h0);
      g   = RR ? (c % 3) : 0;
      one = 3'b001 << g;
      #1;
      check($sformatf("all3_wait_c%0d", c), 32'(mem_wait), 32'(3'b111 & ~one));
      check($sformatf("all3_rdata_g_c%0d", c), mem_rdata[g], 32'h00AD00EF);
      check($sformatf("all3_rdata_n_c%0d", c), mem_rdata[(g + 1) % 3], 32'h0);
      tick();
    end
    idle();

    for (int c = 0; c < 4; c++) begin
      req(0, 1'b0, 32'h20, 32'h0, 4'h0);
      req(1, 1'b0, 32'h20, 32'h0, 4'h0);
      g   = RR ? (c % 2) : 0;
      one = 3'b001 << g;
      #1;
      check($sformatf("p01_wait_c%0d", c), 32'(mem_wait), 32'(3'b011 & ~one));
      check($sformatf("p01_rdata_c%0d", c), mem_rdata[g], 32'h12345678);
      tick();
    end
    idle();

    req(1, 1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111);
    #1;
    check("oor_wr_wait", 32'(mem_wait), 32'h0);
    tick(); idle();
    #1;
    check("oor_err", 32'(err), 32'h1);
    check("oor_errport", 32'(err_port), 32'h1);
    req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("oor_word0_intact", mem_rdata[0], 32'h0);
    tick(); idle();
    req(0, 1'b0, 32'h800, 32'h0, 4'h0);
    #1;
    check("oor_rd_data", mem_rdata[0], 32'h0);
    tick(); idle();
    #1;
    check("oor_err_sticky", 32'(err), 32'h1);
    check("oor_errport_kept", 32'(err_port), 32'h1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      check($sformatf("mid_done_c%0d", c), 32'(init_done), 32'h0);
      tick();
    end
    rst = 1'b1;
    tick();
    #1;
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_errport", 32'(err_port), 32'h0);
    check("mid_rst_done", 32'(init_done), 32'h0);
    rst = 1'b0;
    clear_sequence("clr2");

    req(0, 1'b0, 32'h1FC, 32'h0, 4'h0);
    #1;
    check("clr2_1fc_zero", mem_rdata[0], 32'h0);
    tick(); idle();
    req(2, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    check("clr2_10_zero", mem_rdata[2], 32'h0);
    tick(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
